// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t  : fetch FSM encoding (FETCH, HOLD, DISCARD)
//   NOP_INST       : word presented on IF/ID when it holds no instruction
//   PC_STEP        : PC increment per fetched word
//   PC_READ_OFFSET : value added to an instruction address for decode's R15 read
//   sat_inc        : saturating 32-bit increment used by the optional counters
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST       = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    sat_inc = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding slot for a fetched word that arrived
// while decode was stalled.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture word_in/pc_in and mark the entry valid
//   drain     : entry has been consumed; mark it empty
//   clear     : discard the entry (redirect); wins over load and drain
//   word_in   : fetched instruction to store
//   pc_in     : PC value (instruction address + 8) belonging to word_in
//   word, pc, valid : stored entry
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [N-1:0] word_in,
  input  logic [N-1:0] pc_in,
  output logic [N-1:0] word,
  output logic [N-1:0] pc,
  output logic         valid
);

  // Entry storage: clear beats load, load beats drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= N'(NOP_INST);
      pc    <= {N{1'b0}};
      valid <= 1'b0;
    end else if (clear) begin
      word  <= N'(NOP_INST);
      pc    <= {N{1'b0}};
      valid <= 1'b0;
    end else if (load) begin
      word  <= word_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one outstanding
// request at a time to instruction memory and feeds decode through the
// IF/ID register, with a one-entry skid buffer for decode stalls and
// discard of in-flight fetches on redirects.
//   clk, rst       : clock, asynchronous active-high reset
//   stall          : decode hazard, hold IF/ID
//   branch_taken   : redirect request (beats stall)
//   branch_target  : redirect address, low two bits ignored
//   imem_req/addr  : fetch request and its address (address stable while req=1)
//   imem_ack/rdata : memory response, ack only honoured while imem_req=1
//   inst, pc_out, inst_valid : IF/ID register towards decode
// Optional build macro FETCH_PERF_EN adds fetch_count and bubble_count
// (32-bit saturating counters cleared by rst).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] inst,
  output logic [N-1:0] pc_out,
  output logic         inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  bubble_count
`endif
);

  fetch_state_t state_r, state_nx;
  logic [N-1:0] pc_r, pc_nx;
  logic [N-1:0] addr_nx;
  logic [N-1:0] target_s;
  logic [N-1:0] pc_plus_step_s;
  logic [N-1:0] pc_plus_read_s;
  logic         ack_s;

  logic         ifid_upd_s;
  logic [N-1:0] ifid_inst_s;
  logic [N-1:0] ifid_pc_s;
  logic         ifid_valid_s;
  logic         accept_s;

  logic         skid_load_s;
  logic         skid_drain_s;
  logic         skid_clear_s;
  logic [N-1:0] skid_word_s;
  logic [N-1:0] skid_pc_s;
  logic         skid_valid_s;

  // A response only counts while our own registered request is up.
  assign ack_s          = imem_ack & imem_req;
  assign target_s       = {branch_target[N-1:2], 2'b00};
  assign pc_plus_step_s = pc_r + N'(PC_STEP);
  assign pc_plus_read_s = pc_r + N'(PC_READ_OFFSET);

  fetch_skid_buffer #(.N(N)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load_s),
    .drain   (skid_drain_s),
    .clear   (skid_clear_s),
    .word_in (imem_rdata),
    .pc_in   (pc_plus_read_s),
    .word    (skid_word_s),
    .pc      (skid_pc_s),
    .valid   (skid_valid_s)
  );

  // Next-state, PC, address and IF/ID update decisions.
  always_comb begin
    state_nx     = state_r;
    pc_nx        = pc_r;
    addr_nx      = imem_addr;
    ifid_upd_s   = 1'b0;
    ifid_inst_s  = N'(NOP_INST);
    ifid_pc_s    = pc_out;
    ifid_valid_s = 1'b0;
    accept_s     = 1'b0;
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_clear_s = 1'b0;

    if (branch_taken) begin
      // Redirect: invalidate IF/ID even under stall, flush the skid entry.
      pc_nx        = target_s;
      skid_clear_s = 1'b1;
      ifid_upd_s   = 1'b1;
      case (state_r)
        FETCH:   state_nx = (imem_req && !ack_s) ? DISCARD : FETCH;
        HOLD:    state_nx = FETCH;
        DISCARD: state_nx = ack_s ? FETCH : DISCARD;
        default: state_nx = FETCH;
      endcase
      // An unanswered request must keep its original address until acked.
      addr_nx = (state_nx == DISCARD) ? imem_addr : target_s;
    end else begin
      case (state_r)
        FETCH: begin
          if (ack_s) begin
            accept_s = 1'b1;
            pc_nx    = pc_plus_step_s;
            addr_nx  = pc_plus_step_s;
            if (!stall) begin
              ifid_upd_s   = 1'b1;
              ifid_inst_s  = imem_rdata;
              ifid_pc_s    = pc_plus_read_s;
              ifid_valid_s = 1'b1;
            end else begin
              skid_load_s = 1'b1;
              state_nx    = HOLD;
            end
          end else begin
            ifid_upd_s = !stall;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_upd_s   = 1'b1;
            ifid_inst_s  = skid_word_s;
            ifid_pc_s    = skid_pc_s;
            ifid_valid_s = skid_valid_s;
            skid_drain_s = 1'b1;
            state_nx     = FETCH;
          end else begin
            ifid_upd_s = 1'b0;
          end
        end
        DISCARD: begin
          ifid_upd_s = !stall;
          if (ack_s) begin
            // pc_r already holds the redirect target.
            state_nx = FETCH;
            addr_nx  = pc_r;
          end else begin
            state_nx = DISCARD;
          end
        end
        default: begin
          state_nx   = FETCH;
          addr_nx    = pc_r;
          ifid_upd_s = !stall;
        end
      endcase
    end
  end

  // FSM, PC and memory-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_r      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state_r   <= state_nx;
      pc_r      <= pc_nx;
      imem_req  <= (state_nx != HOLD);
      imem_addr <= addr_nx;
    end
  end

  // IF/ID register: written every non-stalled cycle, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= N'(NOP_INST);
      pc_out     <= {N{1'b0}};
      inst_valid <= 1'b0;
    end else if (ifid_upd_s) begin
      inst       <= ifid_inst_s;
      pc_out     <= ifid_pc_s;
      inst_valid <= ifid_valid_s;
    end else begin
      inst       <= inst;
      pc_out     <= pc_out;
      inst_valid <= inst_valid;
    end
  end

`ifdef FETCH_PERF_EN
  logic in_valid_s;

  // Validity of what IF/ID will hold after this edge.
  assign in_valid_s = ifid_upd_s ? ifid_valid_s : inst_valid;

  // Saturating fetch and bubble counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      fetch_count  <= accept_s ? sat_inc(fetch_count) : fetch_count;
      bubble_count <= (!stall && !in_valid_s) ? sat_inc(bubble_count) : bubble_count;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the hybrid pipeline and the producer side of the decode stage's instruction/PC inputs. Holds the program counter, issues single-outstanding requests to instruction memory over a req/ack handshake, and presents instructions to decode through the IF/ID register. A one-entry skid buffer supports decode stalls, and redirects on taken branches discard in-flight fetches.

## Interface
- N, 32, instruction/address width
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode hazard; hold IF/ID contents
- branch_taken  in  1  redirect request from execute
- branch_target  in  N  redirect address; bits [1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address, stable while imem_req=1
- imem_ack  in  1  imem_rdata valid; sampled only while imem_req=1
- imem_rdata  in  N  fetched instruction
- inst  out  N  IF/ID instruction to decode
- pc_out  out  N  IF/ID PC value for decode's R15 read = instruction address + 8
- inst_valid  out  1  IF/ID holds a real instruction

## Operation
- State machine: FETCH, HOLD, DISCARD. Reset → FETCH.
- FETCH: imem_req=1, imem_addr=pc_reg. Without ack, stay and hold the address. On ack:
  - If IF/ID can accept (stall=0), load IF/ID with inst=imem_rdata, pc_out=pc_reg+8, inst_valid=1.
  - If stall=1, write the word and its PC into the skid buffer and go to HOLD.
  - In both cases pc_reg += 4.
- HOLD: imem_req=0. When stall=0, move the buffer into IF/ID and go to FETCH.
- DISCARD: the redirect arrived while a request was outstanding without ack.
  - Keep imem_req=1 and the old address until ack, then drop the data.
  - Go to FETCH; pc_reg already holds the target.
- IF/ID with stall=0 and no new word: inst=NOP_INST, inst_valid=0 (bubble). With stall=1: hold all IF/ID fields.
- branch_taken has highest priority; it beats stall in the same cycle.
  - pc_reg ← {branch_target[N-1:2],2'b00}.
  - IF/ID invalidated (NOP) and skid buffer cleared.
  - From FETCH with no ack: go to DISCARD. From FETCH with ack that cycle: drop the data and stay in FETCH.
  - From HOLD or DISCARD: go to FETCH, or stay in DISCARD if no ack.
- pc_reg arithmetic is modulo 2^N; 0xFFFFFFFC + 4 wraps to 0.
- Reset values: pc_reg=RESET_PC, state=FETCH, imem_req=0 during reset, imem_addr=RESET_PC, inst=NOP_INST, pc_out=0, inst_valid=0, skid buffer empty.
- Reset mid-transaction abandons the outstanding request. Memory must tolerate request withdrawal on reset.

## Timing
- imem_req is registered off state and rises the first clk edge after rst deasserts.
- Zero-wait memory (ack in the request cycle): throughput 1 instr/cycle. A word acked in cycle t is visible on inst/pc_out in cycle t+1.
- Each wait cycle adds one bubble.
- Redirect penalty: with zero-wait memory, the target word appears at IF/ID 2 cycles after the branch_taken cycle.
- Stall release from HOLD: the buffered word reaches IF/ID the next edge, and the new request issues the same cycle.

## Configuration
- FETCH_PERF_EN defined adds:
  - output fetch_count (32 bits): accepted, non-discarded words.
  - output bubble_count (32 bits): cycles with stall=0 and inst_valid=0 at IF/ID input.
  - Both counters clear on rst and saturate at 32'hFFFFFFFF.
- FETCH_PERF_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package fetch_pkg:
  - state enum fetch_state_t {FETCH, HOLD, DISCARD}.
  - NOP_INST = 32'h0.
  - PC_STEP = 4.
  - PC_READ_OFFSET = 8.
- Sub-module fetch_skid_buffer: one entry (word + PC + valid), with load, drain and clear inputs. The FSM and pc_reg stay in fetch_unit.

## Test plan
- Reset release, zero-wait memory returning addr-indexed words → imem_addr 0,4,8,…; inst_valid=1 from the 2nd cycle; pc_out 8,12,16.
- Memory with 3-cycle ack latency → imem_addr held stable 3 cycles; exactly 2 bubbles (inst_valid=0) between instructions.
- stall held 4 cycles while an ack arrives → IF/ID unchanged, word captured in HOLD with imem_req=0; after release, the buffered word appears next cycle and is not lost or duplicated.
- branch_taken (target 0x100) while a request is outstanding with ack 2 cycles later → DISCARD; the returned word is never presented; the next request addr is 0x100.
- branch_taken and stall together, target 0x203 → IF/ID becomes NOP/invalid; the next fetch addr is 0x200.
- pc_reg=0xFFFFFFFC fetch → next imem_addr 0x0. With FETCH_PERF_EN: counts match scenario totals.
